// File: rtl/param_seq_divider_pkg.sv
// param_seq_divider_pkg: shared FSM state encoding for the sequential divider.
package param_seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/param_seq_divider_div_step.sv
// param_seq_divider_div_step: one shift-subtract-restore iteration of the divider.
module param_seq_divider_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] den_i,
    input  logic             bit_i,
    output logic [WIDTH:0]   acc_o,
    output logic             q_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    assign shifted = {acc_i, bit_i};
    assign diff    = shifted - {2'b00, den_i};
    assign q_o     = ~diff[WIDTH+1];
    assign acc_o   = q_o ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/param_seq_divider.sv
// param_seq_divider: multi-cycle radix-2 restoring divider, signed/unsigned per operation.
// Magnitudes are divided; signs, divide-by-zero and min/-1 overflow are applied in FIX.
module param_seq_divider
    import param_seq_divider_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] den,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] rem,
    output logic             done,
    output logic             busy,
    output logic             div_zero,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, dvs_q, num_q;
    logic             qneg_q, rneg_q, zero_q, ovf_pend_q;
    logic [WIDTH-1:0] res_q, rem_q;
    logic             done_q, busy_q, div_zero_q, ovf_q;
    logic             q_d, accept_d;
    logic [WIDTH-1:0] num_abs_d, den_abs_d, res_mag_d, rem_mag_d;

    param_seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
        .acc_i (acc_q),
        .den_i (dvs_q),
        .bit_i (quo_q[WIDTH-1]),
        .acc_o (acc_d),
        .q_o   (q_d)
    );

    // done_q gates acceptance so the cycle presenting done behaves as the DONE cycle
    assign accept_d  = start && !done_q;
    assign num_abs_d = (signed_op && num[WIDTH-1]) ? ~num + WIDTH'(1) : num;
    assign den_abs_d = (signed_op && den[WIDTH-1]) ? ~den + WIDTH'(1) : den;
    assign res_mag_d = qneg_q ? ~quo_q + WIDTH'(1) : quo_q;
    assign rem_mag_d = rneg_q ? ~acc_q[WIDTH-1:0] + WIDTH'(1) : acc_q[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            num_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            zero_q     <= 1'b0;
            ovf_pend_q <= 1'b0;
            res_q      <= '0;
            rem_q      <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            done_q <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    busy_q <= accept_d;
                    if (accept_d) begin
                        state_q    <= CALC;
                        cnt_q      <= '0;
                        acc_q      <= '0;
                        quo_q      <= num_abs_d;
                        dvs_q      <= den_abs_d;
                        num_q      <= num;
                        qneg_q     <= signed_op && (num[WIDTH-1] ^ den[WIDTH-1]);
                        rneg_q     <= signed_op && num[WIDTH-1];
                        zero_q     <= (den == '0);
                        ovf_pend_q <= signed_op && (num == MIN_VAL) && (den == '1);
                    end
                end
                CALC: begin
                    acc_q   <= acc_d;
                    quo_q   <= {quo_q[WIDTH-2:0], q_d};
                    cnt_q   <= cnt_q + CNT_W'(1);
                    state_q <= (cnt_q == CNT_W'(WIDTH-1)) ? FIX : CALC;
                end
                FIX: begin
                    res_q      <= zero_q ? '1 : ovf_pend_q ? MIN_VAL : res_mag_d;
                    rem_q      <= zero_q ? num_q : ovf_pend_q ? '0 : rem_mag_d;
                    div_zero_q <= zero_q;
                    ovf_q      <= ovf_pend_q && !zero_q;
                    state_q    <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign res      = res_q;
    assign rem      = rem_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign div_zero = div_zero_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_param_seq_divider.sv
// tb_param_seq_divider: scoreboard bench; expected results come from integer arithmetic.
module tb_param_seq_divider;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] num, den, res, rem;
        bit           s, dz, ov;
        int           edge_n;
    } exp_t;

    logic         clk = 1'b0, rst = 1'b0, start = 1'b0, signed_op = 1'b0;
    logic [W-1:0] num = '0, den = '0;
    logic [W-1:0] res, rem;
    logic         done, busy, div_zero, ovf;

    exp_t expq[$];
    exp_t me;
    int   n_tests = 0, n_fail = 0, cyc = 0, done_cnt = 0;

    param_seq_divider #(.WIDTH(W), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
        .num(num), .den(den), .res(res), .rem(rem), .done(done),
        .busy(busy), .div_zero(div_zero), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // quotient/remainder from plain integer division (truncates toward zero)
    function automatic exp_t model(input bit s, input logic [W-1:0] n, input logic [W-1:0] d, input int e);
        exp_t x;
        int   a, b;
        x.num = n; x.den = d; x.s = s; x.edge_n = e; x.dz = 1'b0; x.ov = 1'b0;
        if (d == '0) begin
            x.res = '1; x.rem = n; x.dz = 1'b1;
            return x;
        end
        a = s ? int'($signed(n)) : int'(n);
        b = s ? int'($signed(d)) : int'(d);
        x.ov  = s && (a == -(2 ** (W-1))) && (b == -1);
        x.res = W'(a / b);
        x.rem = W'(a % b);
        return x;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (expq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got res=%0h rem=%0h expected no done", res, rem);
            end else begin
                me = expq.pop_front();
                check("res", res, me.res);
                check("rem", rem, me.rem);
                check("div_zero", div_zero, me.dz);
                check("ovf", ovf, me.ov);
                check("latency", cyc - 1 - me.edge_n, W + 2);
                if (!me.dz) check("invariant", W'(res * me.den + rem), me.num);
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 100 && (busy || done); i++) @(negedge clk);
        if (busy || done) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: got busy=%0b expected 0", busy);
        end
    endtask

    task automatic issue(input bit s, input logic [W-1:0] n, input logic [W-1:0] d);
        signed_op = s; num = n; den = d; start = 1'b1;
        expq.push_back(model(s, n, d, cyc));
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic run(input bit s, input logic [W-1:0] n, input logic [W-1:0] d);
        wait_idle();
        issue(s, n, d);
    endtask

    initial begin
        int  d0, n0;
        bit  s;
        logic [W-1:0] rn, rd;
        repeat (3) @(negedge clk);
        check("rst_res", res, 0);
        check("rst_rem", rem, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_div_zero", div_zero, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b1;
        @(negedge clk);
        run(1'b1, 8'h11, 8'hFB);
        run(1'b0, 8'h11, 8'hFB);
        run(1'b0, 8'd200, 8'd7);
        run(1'b1, 8'h80, 8'hFF);
        run(1'b1, 8'hF9, 8'h02);
        run(1'b0, 8'h2A, 8'h00);
        run(1'b1, 8'h2A, 8'h00);
        run(1'b0, 8'hFF, 8'h01);
        // starts during CALC, DONE and the done cycle are all dropped
        wait_idle();
        d0 = done_cnt;
        issue(1'b0, 8'd99, 8'd10);
        for (int k = 1; k <= W + 3; k++) begin
            start = (k == 3 || k == W + 2 || k == W + 3);
            @(negedge clk);
        end
        start = 1'b0;
        check("t5_busy_after_done", busy, 0);
        check("t5_done_count", done_cnt - d0, 1);
        // held start: second operation is accepted once back in IDLE
        wait_idle();
        n0 = cyc;
        signed_op = 1'b0; num = 8'd50; den = 8'd7; start = 1'b1;
        expq.push_back(model(1'b0, 8'd50, 8'd7, n0));
        @(negedge clk);
        signed_op = 1'b1; num = 8'h9C; den = 8'd3;
        expq.push_back(model(1'b1, 8'h9C, 8'd3, n0 + W + 4));
        repeat (W + 4) @(negedge clk);
        start = 1'b0;
        check("held_second_busy", busy, 1);
        // reset mid-operation aborts without done
        wait_idle();
        issue(1'b0, 8'd200, 8'd7);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_res", res, 0);
        check("t6_rem", rem, 0);
        check("t6_done", done, 0);
        check("t6_busy", busy, 0);
        check("t6_div_zero", div_zero, 0);
        check("t6_ovf", ovf, 0);
        void'(expq.pop_back());
        rst = 1'b1;
        d0 = done_cnt;
        repeat (W + 4) @(negedge clk);
        check("t6_no_done", done_cnt - d0, 0);
        run(1'b0, 8'd100, 8'd9);
        for (int i = 0; i < 150; i++) begin
            s  = 1'($urandom_range(0, 1));
            rn = W'($urandom);
            rd = W'($urandom);
            case ($urandom_range(0, 9))
                0: rd = '0;
                1: begin s = 1'b1; rn = 8'h80; rd = 8'hFF; end
                2: rd = W'($urandom_range(1, 3));
                default: ;
            endcase
            run(s, rn, rd);
        end
        wait_idle();
        for (int i = 0; i < 20 && expq.size() != 0; i++) @(negedge clk);
        check("queue_drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
